// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs with issue credits, round-robin drain to one
// registered ROB/PRF writeback port. Define WB_ARB_BYPASS_EN to let arrivals skip an empty FIFO.
module wb_arbiter #(
   parameter int unsigned NUM_SRC      = 3,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned ROB_W        = 5,
   parameter int unsigned PREG_W       = 6,
   parameter int unsigned FLAG_W       = 4,
   parameter int unsigned DATA_W       = 32,
   // rob_wb_t = {cdb.valid, rob_dest, dest, flags, result}; reg_wb_t = {w_v, cdb}
   parameter int unsigned ROB_WB_WIDTH = 1 + ROB_W + PREG_W + FLAG_W + DATA_W,
   parameter int unsigned REG_WB_WIDTH = ROB_WB_WIDTH + 1
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [NUM_SRC-1:0]              src_issue_i,
   output logic [NUM_SRC-1:0]              src_ok_o,
   input  logic [NUM_SRC*ROB_WB_WIDTH-1:0] src_rob_i,
   output logic [ROB_WB_WIDTH-1:0]         wb_rob_o,
   output logic [REG_WB_WIDTH-1:0]         wb_reg_o,
   output logic                            overflow_o,
   input  logic                            mispredict_i
);

   localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned VB = ROB_WB_WIDTH - 1;

   logic [ROB_WB_WIDTH-1:0] r_mem [NUM_SRC][FIFO_DEPTH];
   logic [AW-1:0]           r_wptr [NUM_SRC];
   logic [AW-1:0]           r_rptr [NUM_SRC];
   logic [CW-1:0]           r_count [NUM_SRC];
   logic [CW-1:0]           r_inflight [NUM_SRC];
   logic [SW-1:0]           r_last;
   logic [ROB_WB_WIDTH-1:0] r_wb;
   logic                    r_ovf;

   logic [ROB_WB_WIDTH-1:0] w_src [NUM_SRC];
   logic [ROB_WB_WIDTH-1:0] w_head [NUM_SRC];
   logic [NUM_SRC-1:0]      w_arr, w_empty, w_full, w_cand, w_ok;
   logic [NUM_SRC-1:0]      w_gnt, w_deq, w_byp, w_enq, w_drop;
   logic                    w_gnt_v;
   logic [SW-1:0]           w_gnt_idx;

   always_comb begin
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         w_src[s]   = src_rob_i[s*ROB_WB_WIDTH +: ROB_WB_WIDTH];
         w_arr[s]   = w_src[s][VB] && !mispredict_i;
         w_empty[s] = (r_count[s] == '0);
         w_full[s]  = (r_count[s] == CW'(FIFO_DEPTH));
         // An empty FIFO can only be granted through the bypass path.
         w_head[s]  = w_empty[s] ? w_src[s] : r_mem[s][r_rptr[s]];
`ifdef WB_ARB_BYPASS_EN
         w_cand[s]  = !w_empty[s] || w_arr[s];
`else
         w_cand[s]  = !w_empty[s];
`endif
         w_ok[s]    = ({1'b0, r_count[s]} + {1'b0, r_inflight[s]}) < (CW + 1)'(FIFO_DEPTH);
      end
   end

   // Round-robin search starting one past the last grant.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      w_gnt     = '0;
      w_gnt_v   = 1'b0;
      w_gnt_idx = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         idx = (32'(r_last) + i + 1) % NUM_SRC;
         if (!w_gnt_v && !mispredict_i && w_cand[idx[SW-1:0]]) begin
            w_gnt_v               = 1'b1;
            w_gnt_idx             = idx[SW-1:0];
            w_gnt[idx[SW-1:0]]    = 1'b1;
         end
      end
   end

   assign w_deq  = w_gnt & ~w_empty;
   assign w_byp  = w_gnt & w_empty;
   assign w_enq  = w_arr & ~w_byp & (~w_full | w_deq);
   assign w_drop = w_arr & ~w_byp & w_full & ~w_deq;

   always_ff @(posedge clk_i) begin
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         if (w_enq[s]) r_mem[s][r_wptr[s]] <= w_src[s];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned s = 0; s < NUM_SRC; s++) begin
            r_count[s]    <= '0;
            r_inflight[s] <= '0;
            r_wptr[s]     <= '0;
            r_rptr[s]     <= '0;
         end
         r_last <= SW'(NUM_SRC - 1);
         r_wb   <= '0;
         r_ovf  <= 1'b0;
      end else begin
         for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (mispredict_i) begin
               r_count[s]    <= '0;
               r_inflight[s] <= '0;
               r_wptr[s]     <= '0;
               r_rptr[s]     <= '0;
            end else begin
               r_count[s] <= r_count[s] + CW'(w_enq[s]) - CW'(w_deq[s]);
               r_wptr[s]  <= r_wptr[s] + AW'(w_enq[s]);
               r_rptr[s]  <= r_rptr[s] + AW'(w_deq[s]);
               // Saturate so an uncredited arrival cannot wrap the counter.
               if (src_issue_i[s] && !w_src[s][VB]) begin
                  if (r_inflight[s] != '1) r_inflight[s] <= r_inflight[s] + 1'b1;
               end else if (!src_issue_i[s] && w_src[s][VB]) begin
                  if (r_inflight[s] != '0) r_inflight[s] <= r_inflight[s] - 1'b1;
               end
            end
         end
         if (w_gnt_v) r_last <= w_gnt_idx;
         r_wb  <= w_gnt_v ? w_head[w_gnt_idx] : '0;
         r_ovf <= r_ovf | (|w_drop);
      end
   end

   assign src_ok_o   = w_ok;
   assign wb_rob_o   = r_wb;
   assign wb_reg_o   = {r_wb[VB], r_wb};
   assign overflow_o = r_ovf;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: vector table for the burst case, hand sequences
// for latency, credit, mispredict and overflow.
module tb_wb_arbiter;

   localparam int W = 48;
`ifdef WB_ARB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [2:0]     src_issue;
   logic [2:0]     src_ok;
   logic [3*W-1:0] src_rob;
   logic [W-1:0]   wb_rob;
   logic [W:0]     wb_reg;
   logic           ovf;
   logic           mispredict;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk_i       (clk),
      .reset_i     (rst),
      .src_issue_i (src_issue),
      .src_ok_o    (src_ok),
      .src_rob_i   (src_rob),
      .wb_rob_o    (wb_rob),
      .wb_reg_o    (wb_reg),
      .overflow_o  (ovf),
      .mispredict_i(mispredict)
   );

   typedef struct {
      logic [2:0] arr;
      logic       exp_v;
      int         exp_s;
      int         exp_k;
      logic [2:0] exp_ok;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [W-1:0] pay(input int s, input int k);
      logic [31:0] res;
      res = 32'h1000 * s + k;
      return {1'b1, 5'(s * 8 + k), 6'(s), 4'(k), res};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] m, input int k);
      for (int s = 0; s < 3; s++) src_rob[s*W +: W] = m[s] ? pay(s, k) : '0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic flush;
      tick();
      mispredict = 1'b1;
      tick();
      mispredict = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] exp_wb;
      logic         seen;

      // Burst of all three sources for two cycles: grants 0,1,2,0,1,2 back to back.
      vecs[0] = '{3'b111, 1'b1, 0, 0, 3'b111, 1'b0};
      vecs[1] = '{3'b111, 1'b1, 1, 0, 3'b111, 1'b0};
      vecs[2] = '{3'b000, 1'b1, 2, 0, 3'b111, 1'b0};
      vecs[3] = '{3'b000, 1'b1, 0, 1, 3'b111, 1'b0};
      vecs[4] = '{3'b000, 1'b1, 1, 1, 3'b111, 1'b0};
      vecs[5] = '{3'b000, 1'b1, 2, 1, 3'b111, 1'b0};
      vecs[6] = '{3'b000, 1'b0, 0, 0, 3'b111, 1'b0};
      vecs[7] = '{3'b000, 1'b0, 0, 0, 3'b111, 1'b0};

      rst        = 1'b1;
      src_issue  = '0;
      src_rob    = '0;
      mispredict = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("reset_wb_rob", 64'(wb_rob), 64'd0);
      check("reset_wb_reg", 64'(wb_reg), 64'd0);
      check("reset_src_ok", 64'(src_ok), 64'd7);
      check("reset_ovf", 64'(ovf), 64'd0);

      for (int k = 0; k < 8 + LAT; k++) begin
         tick();
         if (k >= LAT) begin
            exp_wb = vecs[k-LAT].exp_v ? pay(vecs[k-LAT].exp_s, vecs[k-LAT].exp_k) : '0;
            check($sformatf("burst_wb[%0d]", k - LAT), 64'(wb_rob), 64'(exp_wb));
            check($sformatf("burst_ok[%0d]", k - LAT), 64'(src_ok), 64'(vecs[k-LAT].exp_ok));
            check($sformatf("burst_ovf[%0d]", k - LAT), 64'(ovf), 64'(vecs[k-LAT].exp_ovf));
         end
         drive((k < 8) ? vecs[k].arr : 3'b000, k);
      end

      // Single uncontested result on source 1.
      tick();
      exp_wb = {1'b1, 5'd5, 6'd0, 4'd0, 32'h1234};
      src_rob[W +: W] = exp_wb;
      for (int i = 1; i <= LAT; i++) begin
         tick();
         if (i == 1) src_rob = '0;
         if (i < LAT) check("lat_early_valid", 64'(wb_rob[W-1]), 64'd0);
      end
      check("lat_wb_rob", 64'(wb_rob), 64'(exp_wb));
      check("lat_wb_reg", 64'(wb_reg), 64'({1'b1, exp_wb}));
      tick();
      check("lat_after_valid", 64'(wb_rob[W-1]), 64'd0);

      // Credit on source 2: four issues exhaust it, first writeback returns it.
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("credit_pre_issue[%0d]", i), 64'(src_ok[2]), 64'd1);
         src_issue = 3'b100;
      end
      tick();
      src_issue = '0;
      check("credit_exhausted", 64'(src_ok), 64'd3);
      src_rob[2*W +: W] = pay(2, 30);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         src_rob = '0;
         if (wb_rob[W-1]) begin
            seen = 1'b1;
            check("credit_wb", 64'(wb_rob), 64'(pay(2, 30)));
            check("credit_back", 64'(src_ok[2]), 64'd1);
         end else begin
            check("credit_still_out", 64'(src_ok[2]), 64'd0);
         end
      end
      if (!seen) check("credit_wb_timeout", 64'd0, 64'd1);
      flush();
      check("credit_flushed_ok", 64'(src_ok), 64'd7);

      // Mispredict with buffered entries, outstanding issues and a same-cycle issue.
      tick();
      src_issue = 3'b111;
      tick();
      drive(3'b111, 20);
      tick();
      drive(3'b111, 21);
      tick();
      drive(3'b111, 22);
      mispredict = 1'b1;
      tick();
      drive(3'b000, 0);
      mispredict = 1'b0;
      src_issue  = 3'b001;
      check("flush_valid", 64'(wb_rob), 64'd0);
      check("flush_ok", 64'(src_ok), 64'd7);
      tick();
      check("flush_valid_1", 64'(wb_rob), 64'd0);
      tick();
      check("flush_valid_2", 64'(wb_rob), 64'd0);
      tick();
      src_issue = '0;
      check("flush_issue_ignored", 64'(src_ok[0]), 64'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("flush_no_stale[%0d]", i), 64'(wb_rob[W-1]), 64'd0);
      end
      flush();

      // Overflow: every source fed every cycle, drain is one per cycle in total.
      check("ovf_before", 64'(ovf), 64'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         drive(3'b111, 40 + k);
      end
      tick();
      drive(3'b000, 0);
      check("ovf_set", 64'(ovf), 64'd1);
      flush();
      repeat (3) tick();
      check("ovf_sticky", 64'(ovf), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("ovf_reset", 64'(ovf), 64'd0);
      check("ovf_reset_ok", 64'(src_ok), 64'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
